// File: rtl/regfile_pkg.sv
// Shared sizes, types and the one-hot integrity helper for the one-hot register file.
package regfile_pkg;

    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    typedef logic [NREGS-1:0]  onehot_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Clearing the lowest set bit leaves zero only for zero or a single set bit.
    function automatic logic is_onehot_or_zero(input onehot_t v);
        return (v & (v - onehot_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot decoder: classifies a select vector and recovers the
// index of its set bit.
module onehot_to_idx
    import regfile_pkg::*;
(
    input  onehot_t sel,
    output logic    valid,
    output logic    multi,
    output addr_t   idx
);

    always_comb begin
        multi = !is_onehot_or_zero(sel);
        valid = (sel != '0) && !multi;
        idx   = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
                idx = addr_t'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_regfile.sv
// 8-entry register file written through a one-hot select, with two registered
// read ports and one-hot integrity flags. Define ONEHOT_REGFILE_BYPASS_EN for write-first reads.
module onehot_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  onehot_t          we_sel,
    input  logic [WIDTH-1:0] wd,
    input  addr_t            ra0,
    input  addr_t            ra1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic             sel_err,
    output logic             sel_err_sticky
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] rd0_q, rd0_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    logic  sel_valid;
    logic  sel_multi;
    addr_t sel_idx;
    logic  wr_en;

    onehot_to_idx u_dec (
        .sel   (we_sel),
        .valid (sel_valid),
        .multi (sel_multi),
        .idx   (sel_idx)
    );

    // A legal select of a hard-wired zero register is accepted but stores nothing.
    assign wr_en = sel_valid && !((ZERO_R0 != 0) && (sel_idx == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[sel_idx] = wd;
        end
    end

    always_comb begin
        rd0_d = regs_q[ra0];
        rd1_d = regs_q[ra1];
`ifdef ONEHOT_REGFILE_BYPASS_EN
        if (wr_en && (sel_idx == ra0)) rd0_d = wd;
        if (wr_en && (sel_idx == ra1)) rd1_d = wd;
`endif
        if ((ZERO_R0 != 0) && (ra0 == '0)) rd0_d = '0;
        if ((ZERO_R0 != 0) && (ra1 == '0)) rd1_d = '0;
    end

    always_comb begin
        err_d    = sel_multi;
        sticky_d = sticky_q | sel_multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rd0_q    <= '0;
            rd1_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign rd0            = rd0_q;
    assign rd1            = rd1_q;
    assign sel_err        = err_q;
    assign sel_err_sticky = sticky_q;

endmodule

// File: doc/onehot_regfile.md
Name: onehot_regfile

Overview:
- 8-entry register file that consumes the one-hot write-select produced by the 3-to-8 decoder stage directly upstream.
- Decoder output drives we_sel.
- Two independent read ports with registered outputs, plus one write port.
- Checks one-hot integrity of we_sel and flags violations, so a faulty decoder is caught in-system.

Parameters:
- WIDTH, 8, data width of each register and of the read/write data ports.
- ZERO_R0, 0, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- we_sel  input  8  one-hot write select; bit i writes register i; all-zero means no write.
- wd  input  WIDTH  write data.
- ra0  input  3  read address, port 0.
- ra1  input  3  read address, port 1.
- rd0  output  WIDTH  registered read data, port 0.
- rd1  output  WIDTH  registered read data, port 1.
- sel_err  output  1  one-cycle pulse: we_sel had more than one bit set last cycle.
- sel_err_sticky  output  1  set by any sel_err, cleared only by rst.

Behaviour:
- Reset (rst high at rising edge):
  - all 8 registers, rd0, rd1, sel_err and sel_err_sticky go to 0.
  - we_sel is ignored in that cycle.
  - Reset mid-sequence discards any write presented in the same cycle.
- Write:
  - At a rising edge with rst low and exactly one bit i of we_sel set, reg[i] <= wd.
  - we_sel == 0: no write, no error.
- Illegal select (two or more bits set):
  - no register is modified.
  - sel_err = 1 on the following cycle only.
  - sel_err_sticky = 1 from the following cycle until reset.
  - Back-to-back illegal selects hold sel_err high for consecutive cycles.
- Read:
  - rdN <= reg[raN] at each rising edge.
  - Latency is one cycle from address to data.
  - Both ports may read the same address simultaneously.
- Read-during-write to the same address: rdN returns the old contents unless BYPASS_EN is defined (see Optional Feature).
- ZERO_R0 = 1:
  - we_sel = 8'b0000_0001 is legal (no error) but no write occurs.
  - reads of address 0 return 0.
- Widths:
  - wd is stored unmodified; no arithmetic.
  - Address and one-hot index are both 3 bits; all 8 addresses are valid, so there is no out-of-range case.

Optional Feature:
- Macro ONEHOT_REGFILE_BYPASS_EN.
- Defined: a read in the same cycle as a legal write to the same register captures wd into rdN (write-first).
  - An illegal or blocked write is never bypassed.
  - With ZERO_R0 = 1, address 0 still reads 0.
- Undefined: read-first; rdN captures the pre-write contents.

Decomposition:
- Package regfile_pkg holds:
  - NREGS = 8, ADDR_W = 3.
  - typedef onehot_t (logic [NREGS-1:0]) and typedef addr_t (logic [ADDR_W-1:0]).
  - function is_onehot_or_zero.
- Sub-module onehot_to_idx (combinational) takes onehot_t and produces:
  - valid (exactly one bit set).
  - multi (two or more bits set).
  - idx (addr_t).
- The top level uses valid/idx for the write and for the bypass compare, and multi for sel_err.

Test Plan:
- Reset then read all addresses on both ports -> rd0 = rd1 = 0 one cycle after each address; sel_err = sel_err_sticky = 0.
- Write 8'hA0+i via we_sel = 1<<i for i = 0..7, then read ra0 = i, ra1 = 7-i -> rd0 = 8'hA0+i and rd1 = 8'hA7-i, one cycle after each address is presented.
- we_sel = 8'b0001_0010, wd = 8'hFF -> reg1 and reg4 unchanged; sel_err high exactly one cycle; sel_err_sticky stays 1 until rst; a subsequent legal write still succeeds.
- Same cycle: we_sel = 8'b0000_1000, wd = 8'h5C, ra0 = 3, reg3 previously 8'h33:
  - with macro, rd0 = 8'h5C.
  - without macro, rd0 = 8'h33; next-cycle read gives 8'h5C.
- ZERO_R0 = 1: we_sel = 8'h01, wd = 8'h77, then read ra0 = 0 -> rd0 = 0 and sel_err = 0.
- rst asserted in the same cycle as we_sel = 8'h04, wd = 8'h99 -> reg2 = 0 afterwards; rd0/rd1 = 0 in the cycle after reset; sticky flag cleared.
